// File: rtl/whack_pkg.sv
// Shared encodings for the whack-a-mole game flow: FSM states, mode codes
// and button bit positions.
package whack_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_COUNTDOWN = 2'b01,
      ST_PLAY      = 2'b10,
      ST_DONE      = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      MODE_NONE   = 2'b00,
      MODE_EASY   = 2'b01,
      MODE_MEDIUM = 2'b10,
      MODE_HARD   = 2'b11
   } mode_t;

   localparam int BTN_EASY   = 0;
   localparam int BTN_MEDIUM = 1;
   localparam int BTN_HARD   = 2;
   localparam int BTN_START  = 3;

endpackage

// File: rtl/whack_btn_edge.sv
// Registers the four button levels and produces a registered one-cycle
// strobe on each rising edge, so a held button acts exactly once.
module whack_btn_edge (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic [3:0] buttons_i,
   output logic [3:0] press_o
);

   logic [3:0] buttons_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         buttons_q <= '0;
         press_o   <= '0;
      end else begin
         buttons_q <= buttons_i;
         press_o   <= buttons_i & ~buttons_q;
      end
   end

endmodule

// File: rtl/whack_game_sequencer.sv
// Game-flow FSM (IDLE/COUNTDOWN/PLAY/DONE) with timer, score and display select.
// Define WHACK_HIGH_SCORE_EN to keep a best-score register across games.
module whack_game_sequencer
   import whack_pkg::*;
#(
   parameter int unsigned COUNTDOWN_SEC = 3,
   parameter int unsigned GAME_SEC      = 30,
   parameter int unsigned SCORE_W       = 16
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               tick_1hz_i,
   input  logic               tick_2hz_i,
   input  logic               tick_5hz_i,
   input  logic [3:0]         buttons_i,
   input  logic               whack_i,
   output logic [1:0]         mode_o,
   output logic [1:0]         state_o,
   output logic               mole_step_o,
   output logic               game_active_o,
   output logic               game_over_o,
   output logic [7:0]         time_left_o,
   output logic [SCORE_W-1:0] score_o,
   output logic [SCORE_W-1:0] high_score_o,
   output logic [15:0]        display_value_o
);

   localparam logic [3:0]         COUNT_INIT = 4'(COUNTDOWN_SEC);
   localparam logic [7:0]         TIME_INIT  = 8'(GAME_SEC);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
   localparam logic [SCORE_W-1:0] SCORE_ONE  = 1;

   logic [3:0]         press;
   state_t             state_q, state_d;
   mode_t              mode_q, mode_d;
   logic [3:0]         count_q, count_d;
   logic [7:0]         time_q, time_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [15:0]        display_q, display_d;
   logic               active_q, over_q;

   whack_btn_edge u_btn_edge (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .buttons_i (buttons_i),
      .press_o   (press)
   );

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      count_d = count_q;
      time_d  = time_q;
      score_d = score_q;
      unique case (state_q)
         ST_IDLE: begin
            // Start is judged against the mode held before this cycle's press.
            if (press[BTN_START] && mode_q != MODE_NONE) begin
               state_d = ST_COUNTDOWN;
               count_d = COUNT_INIT;
            end
            if (press[BTN_EASY])        mode_d = MODE_EASY;
            else if (press[BTN_MEDIUM]) mode_d = MODE_MEDIUM;
            else if (press[BTN_HARD])   mode_d = MODE_HARD;
         end
         ST_COUNTDOWN: begin
            if (tick_1hz_i) begin
               if (count_q > 4'd1) begin
                  count_d = count_q - 4'd1;
               end else begin
                  state_d = ST_PLAY;
                  count_d = '0;
                  time_d  = TIME_INIT;
                  score_d = '0;
               end
            end
         end
         ST_PLAY: begin
            if (whack_i && score_q != SCORE_MAX) score_d = score_q + SCORE_ONE;
            if (tick_1hz_i) begin
               if (time_q > 8'd1) begin
                  time_d = time_q - 8'd1;
               end else begin
                  time_d  = '0;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (press[BTN_START]) state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      display_d = '0;
      unique case (state_d)
         ST_IDLE:      display_d = 16'(mode_d);
         ST_COUNTDOWN: display_d = 16'(count_d);
         ST_PLAY:      display_d = 16'(time_d);
         ST_DONE:      display_d = 16'(score_d);
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_NONE;
         count_q   <= '0;
         time_q    <= '0;
         score_q   <= '0;
         display_q <= '0;
         active_q  <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         count_q   <= count_d;
         time_q    <= time_d;
         score_q   <= score_d;
         display_q <= display_d;
         active_q  <= (state_d == ST_PLAY);
         over_q    <= (state_d == ST_DONE);
      end
   end

   // Mole strobe follows the input tick in the same cycle, gated by state.
   always_comb begin
      mole_step_o = 1'b0;
      if (state_q == ST_PLAY) begin
         unique case (mode_q)
            MODE_EASY:   mole_step_o = tick_1hz_i;
            MODE_MEDIUM: mole_step_o = tick_2hz_i;
            MODE_HARD:   mole_step_o = tick_5hz_i;
            default:     mole_step_o = 1'b0;
         endcase
      end
   end

`ifdef WHACK_HIGH_SCORE_EN
   logic [SCORE_W-1:0] high_q;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         high_q <= '0;
      end else if (state_q == ST_PLAY && state_d == ST_DONE && score_d > high_q) begin
         high_q <= score_d;
      end
   end

   assign high_score_o = high_q;
`else
   assign high_score_o = '0;
`endif

   assign mode_o          = mode_q;
   assign state_o         = state_q;
   assign game_active_o   = active_q;
   assign game_over_o     = over_q;
   assign time_left_o     = time_q;
   assign score_o         = score_q;
   assign display_value_o = display_q;

endmodule

// File: tb/tb_whack_game_sequencer.sv
// Self-checking bench for whack_game_sequencer: directed scenarios plus a
// randomized run, all against a cycle-level behavioural game model.
module tb_whack_game_sequencer;

   localparam int CD = 3;
   localparam int GS = 30;
   localparam int SW = 16;
   localparam int SMAX = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic          tick_1hz_i = 1'b0, tick_2hz_i = 1'b0, tick_5hz_i = 1'b0;
   logic [3:0]    buttons_i = 4'b0;
   logic          whack_i = 1'b0;
   logic [1:0]    mode_o, state_o;
   logic          mole_step_o, game_active_o, game_over_o;
   logic [7:0]    time_left_o;
   logic [SW-1:0] score_o, high_score_o;
   logic [15:0]   display_value_o;
   logic [61:0]   obs;

   int n_cmp = 0;
   int n_bad = 0;

   // Model of the game as seen at the outputs.
   int         m_state, m_mode, m_count, m_time, m_score, m_high;
   logic [3:0] m_press, m_bq;
   logic       exp_mole, obs_mole;

   whack_game_sequencer #(.COUNTDOWN_SEC(CD), .GAME_SEC(GS), .SCORE_W(SW)) dut (
      .clock_i         (clk),
      .reset_i         (reset_i),
      .tick_1hz_i      (tick_1hz_i),
      .tick_2hz_i      (tick_2hz_i),
      .tick_5hz_i      (tick_5hz_i),
      .buttons_i       (buttons_i),
      .whack_i         (whack_i),
      .mode_o          (mode_o),
      .state_o         (state_o),
      .mole_step_o     (mole_step_o),
      .game_active_o   (game_active_o),
      .game_over_o     (game_over_o),
      .time_left_o     (time_left_o),
      .score_o         (score_o),
      .high_score_o    (high_score_o),
      .display_value_o (display_value_o)
   );

   always #5 clk = ~clk;

   assign obs = {state_o, mode_o, game_active_o, game_over_o, time_left_o,
                 score_o, high_score_o, display_value_o};

   task automatic model_edge(input logic r, input logic [3:0] b, input logic t1, input logic w);
      logic [3:0] p;
      logic       go;
      if (r) begin
         m_state = 0; m_mode = 0; m_count = 0; m_time = 0; m_score = 0; m_high = 0;
         m_press = '0; m_bq = '0;
      end else begin
         p = m_press;
         m_press = b & ~m_bq;
         m_bq = b;
         case (m_state)
            0: begin
               go = p[3] && (m_mode != 0);
               if (p[0]) m_mode = 1;
               else if (p[1]) m_mode = 2;
               else if (p[2]) m_mode = 3;
               if (go) begin m_state = 1; m_count = CD; end
            end
            1: if (t1) begin
               if (m_count > 1) m_count = m_count - 1;
               else begin m_state = 2; m_time = GS; m_score = 0; end
            end
            2: begin
               if (w && m_score < SMAX) m_score = m_score + 1;
               if (t1) begin
                  if (m_time > 1) m_time = m_time - 1;
                  else begin
                     m_time = 0;
                     m_state = 3;
`ifdef WHACK_HIGH_SCORE_EN
                     if (m_score > m_high) m_high = m_score;
`endif
                  end
               end
            end
            default: if (p[3]) m_state = 0;
         endcase
      end
   endtask

   function automatic logic [61:0] model_vec();
      int disp;
      disp = (m_state == 0) ? m_mode : (m_state == 1) ? m_count :
             (m_state == 2) ? m_time : (m_score & 16'hFFFF);
      return {2'(m_state), 2'(m_mode), (m_state == 2), (m_state == 3), 8'(m_time),
              16'(m_score), 16'(m_high), 16'(disp)};
   endfunction

   // One clock: drive at negedge, capture the combinational strobe, step the model at posedge.
   task automatic cyc(input logic r, input logic [3:0] b, input logic t1, input logic t2,
                      input logic t5, input logic w);
      @(negedge clk);
      reset_i = r; buttons_i = b; tick_1hz_i = t1; tick_2hz_i = t2; tick_5hz_i = t5; whack_i = w;
      #1;
      exp_mole = (m_state == 2) && ((m_mode == 1 && t1) || (m_mode == 2 && t2) || (m_mode == 3 && t5));
      obs_mole = mole_step_o;
      @(posedge clk);
      model_edge(r, b, t1, w);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic press(input logic [3:0] b);
      cyc(1'b0, b, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Plays one full game from IDLE back to DONE; no checks inside.
   task automatic play_game(input logic [3:0] mode_btn, input int whacks);
      int guard;
      press(mode_btn);
      press(4'b1000);
      idle_cycles(1);
      for (int i = 0; i < CD; i++) cyc(1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < whacks; i++) cyc(1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      guard = 0;
      while (m_state == 2 && guard < 300) begin
         cyc(1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         guard++;
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== 62'b0) begin
         n_bad++; $display("FAIL reset_outputs: got %h want 0", obs);
      end
      n_cmp++;
      if (obs_mole !== 1'b0) begin
         n_bad++; $display("FAIL reset_mole: got %b want 0", obs_mole);
      end
   endtask

   task automatic test_mode_select();
      press(4'b1000);
      idle_cycles(1);
      n_cmp++;
      if (state_o !== 2'b00 || mode_o !== 2'b00) begin
         n_bad++; $display("FAIL start_no_mode: state %b mode %b want 00 00", state_o, mode_o);
      end
      // Mode and start together: mode updates, start sees the old mode 00.
      press(4'b1001);
      idle_cycles(1);
      n_cmp++;
      if (state_o !== 2'b00 || mode_o !== 2'b01) begin
         n_bad++; $display("FAIL mode_and_start: state %b mode %b want 00 01", state_o, mode_o);
      end
      press(4'b0110);
      n_cmp++;
      if (mode_o !== 2'b10) begin
         n_bad++; $display("FAIL mode_priority: got %b want 10", mode_o);
      end
      press(4'b0100);
      cyc(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (state_o !== 2'b00) begin
         n_bad++; $display("FAIL start_latency_early: state %b want 00", state_o);
      end
      cyc(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (state_o !== 2'b01 || mode_o !== 2'b11 || display_value_o !== 16'd3) begin
         n_bad++;
         $display("FAIL start_countdown: state %b mode %b disp %0d want 01 11 3",
                  state_o, mode_o, display_value_o);
      end
      idle_cycles(2);
      n_cmp++;
      if (obs !== model_vec()) begin
         n_bad++; $display("FAIL held_start: got %h want %h", obs, model_vec());
      end
   endtask

   task automatic test_countdown_to_play();
      cyc(1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (state_o !== 2'b01 || display_value_o !== 16'd1) begin
         n_bad++; $display("FAIL countdown_two_ticks: state %b disp %0d want 01 1", state_o, display_value_o);
      end
      cyc(1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (state_o !== 2'b10 || time_left_o !== 8'(GS) || score_o !== '0 || game_active_o !== 1'b1) begin
         n_bad++;
         $display("FAIL enter_play: state %b time %0d score %0d active %b want 10 %0d 0 1",
                  state_o, time_left_o, score_o, game_active_o, GS);
      end
      cyc(1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (obs_mole !== 1'b1) begin
         n_bad++; $display("FAIL mole_5hz: got %b want 1", obs_mole);
      end
      cyc(1'b0, 4'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs_mole !== 1'b0) begin
         n_bad++; $display("FAIL mole_other_ticks: got %b want 0", obs_mole);
      end
      n_cmp++;
      if (obs !== model_vec()) begin
         n_bad++; $display("FAIL play_tick: got %h want %h", obs, model_vec());
      end
   endtask

   task automatic test_play_to_done();
      int guard = 0;
      for (int i = 0; i < 4; i++) cyc(1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      while (m_time > 1 && guard < 300) begin
         cyc(1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         guard++;
      end
      n_cmp++;
      if (time_left_o !== 8'd1) begin
         n_bad++; $display("FAIL last_second: time %0d want 1", time_left_o);
      end
      cyc(1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (state_o !== 2'b11 || score_o !== 16'd5 || game_over_o !== 1'b1 ||
          display_value_o !== 16'd5 || time_left_o !== 8'd0 || game_active_o !== 1'b0) begin
         n_bad++;
         $display("FAIL game_done: state %b score %0d over %b disp %0d time %0d want 11 5 1 5 0",
                  state_o, score_o, game_over_o, display_value_o, time_left_o);
      end
      cyc(1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (obs !== model_vec() || score_o !== 16'd5) begin
         n_bad++; $display("FAIL done_hold: got %h want %h", obs, model_vec());
      end
   endtask

   task automatic test_reset_mid_play();
      press(4'b1000);
      n_cmp++;
      if (state_o !== 2'b00 || mode_o !== 2'b11 || score_o !== 16'd5) begin
         n_bad++; $display("FAIL done_to_idle: state %b mode %b score %0d want 00 11 5", state_o, mode_o, score_o);
      end
      press(4'b1000);
      idle_cycles(1);
      for (int i = 0; i < CD; i++) cyc(1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) cyc(1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < GS - 12; i++) cyc(1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (score_o !== 16'd7 || time_left_o !== 8'd12 || state_o !== 2'b10) begin
         n_bad++; $display("FAIL mid_play_setup: score %0d time %0d state %b want 7 12 10", score_o, time_left_o, state_o);
      end
      cyc(1'b1, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (obs !== 62'b0) begin
         n_bad++; $display("FAIL reset_mid_play: got %h want 0", obs);
      end
   endtask

   task automatic test_high_score();
      logic [SW-1:0] want;
`ifdef WHACK_HIGH_SCORE_EN
      want = 4;
`else
      want = 0;
`endif
      play_game(4'b0001, 4);
      n_cmp++;
      if (high_score_o !== want || score_o !== 16'd4) begin
         n_bad++; $display("FAIL high_after_first: high %0d score %0d want %0d 4", high_score_o, score_o, want);
      end
      press(4'b1000);
      play_game(4'b0010, 2);
      press(4'b1000);
      n_cmp++;
      if (high_score_o !== want || score_o !== 16'd2 || state_o !== 2'b00) begin
         n_bad++;
         $display("FAIL high_after_second: high %0d score %0d state %b want %0d 2 00",
                  high_score_o, score_o, state_o, want);
      end
   endtask

   task automatic test_random();
      logic [3:0] b = 4'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) == 0) b = 4'($urandom) & 4'($urandom);
         cyc(($urandom_range(0, 599) == 0), b, ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0), ($urandom_range(0, 2) == 0));
         n_cmp++;
         if (obs !== model_vec()) begin
            n_bad++; $display("FAIL random_outputs cyc %0d: got %h want %h", i, obs, model_vec());
         end
         n_cmp++;
         if (obs_mole !== exp_mole) begin
            n_bad++; $display("FAIL random_mole cyc %0d: got %b want %b", i, obs_mole, exp_mole);
         end
      end
   endtask

   task automatic test_saturation();
      int guard = 0;
      cyc(1'b1, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      press(4'b0001);
      press(4'b1000);
      idle_cycles(1);
      for (int i = 0; i < CD; i++) cyc(1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < SMAX; i++) cyc(1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (score_o !== 16'hFFFF) begin
         n_bad++; $display("FAIL score_full: got %h want ffff", score_o);
      end
      cyc(1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (score_o !== 16'hFFFF) begin
         n_bad++; $display("FAIL score_saturate: got %h want ffff", score_o);
      end
      while (m_state == 2 && guard < 300) begin
         cyc(1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1);
         guard++;
      end
      n_cmp++;
      if (obs !== model_vec() || display_value_o !== 16'hFFFF || state_o !== 2'b11) begin
         n_bad++; $display("FAIL saturate_done: got %h want %h", obs, model_vec());
      end
   endtask

   initial begin
      m_state = 0; m_mode = 0; m_count = 0; m_time = 0; m_score = 0; m_high = 0;
      m_press = '0; m_bq = '0;
      test_reset();
      test_mode_select();
      test_countdown_to_play();
      test_play_to_done();
      test_reset_mid_play();
      test_high_score();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/whack_game_sequencer.md
# whack_game_sequencer

Central game-flow controller for the whack-a-mole design: sequences mode selection, pre-game countdown, timed play and game-over, and replaces gated-clock muxing with single-cycle enable strobes. It sits between the clock divider (tick strobes), the button inputs, and the mole/whack/score/display datapath. It owns the game timer, the score counter and the display-value select, so downstream blocks run purely on enables from this block.

## Interface
Parameters:
- COUNTDOWN_SEC, 3: pre-game countdown length in seconds (1..15)
- GAME_SEC, 30: play length in seconds (1..255)
- SCORE_W, 16: score counter width

Ports:
- clock_i  in  1  system clock; all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- tick_1hz_i  in  1  one-cycle strobe, 1 Hz
- tick_2hz_i  in  1  one-cycle strobe, 2 Hz
- tick_5hz_i  in  1  one-cycle strobe, 5 Hz
- buttons_i  in  4  synchronized, debounced; [0] easy, [1] medium, [2] hard, [3] start
- whack_i  in  1  one-cycle pulse per successful whack
- mode_o  out  2  00 none, 01 easy, 10 medium, 11 hard
- state_o  out  2  00 IDLE, 01 COUNTDOWN, 10 PLAY, 11 DONE
- mole_step_o  out  1  mole-advance strobe (PLAY only)
- game_active_o  out  1  high in PLAY
- game_over_o  out  1  high in DONE
- time_left_o  out  8  seconds remaining in PLAY
- score_o  out  SCORE_W  current score
- high_score_o  out  SCORE_W  best score (see Configuration)
- display_value_o  out  16  value for BCD/seven-segment path

## Operation
- Button edges: register buttons_i; press = buttons_i & ~buttons_q. Level-held buttons act once.
- IDLE: mode-button press sets mode_o (simultaneous presses: lowest index wins). Start press with registered mode_o != 00 -> COUNTDOWN, countdown loaded with COUNTDOWN_SEC. Start with mode 00 ignored. Mode and start in same cycle: mode updates, start evaluated against the pre-update mode.
- COUNTDOWN: tick_1hz_i with count > 1 decrements; with count == 1 -> PLAY, time_left = GAME_SEC, score = 0.
- PLAY: mole_step_o = tick_1hz_i / tick_2hz_i / tick_5hz_i for mode 01/10/11, combinationally gated by state. whack_i increments score, saturating at all-ones. tick_1hz_i with time_left > 1 decrements; with time_left == 1 -> time_left = 0, DONE. Whack coincident with final tick is counted.
- DONE: score held; start press -> IDLE (mode_o retained, score retained until next PLAY entry).
- Buttons other than start ignored outside IDLE; whack_i ignored outside PLAY.
- display_value_o: IDLE -> mode_o zero-extended; COUNTDOWN -> count; PLAY -> time_left; DONE -> score (low 16 bits).

## Timing
- Reset (any state, mid-game included): state IDLE, mode_o 00, count 0, time_left_o 0, score_o 0, all strobes/flags 0, display_value_o 0; high_score_o 0 only when reset.
- All outputs registered except mole_step_o (same cycle as input tick, state-gated).
- Button press visible at input cycle N -> state/mode change at output in cycle N+2 (sync register + state register).
- Tick at cycle N -> counter/state change visible at N+1.
- Simultaneous whack_i and transition into DONE: score includes the whack; high-score compare uses updated score.

## Configuration
- WHACK_HIGH_SCORE_EN defined: on PLAY -> DONE, high_score_o = max(high_score_o, final score); survives DONE -> IDLE; cleared only by reset_i.
- Not defined: high_score_o tied to 0, no register inferred.

## Structure
- Shared package whack_pkg: state encoding (IDLE/COUNTDOWN/PLAY/DONE), mode codes (MODE_NONE/EASY/MEDIUM/HARD), button index constants.
- One sub-module: whack_btn_edge (4-bit register plus rising-edge detect). FSM, counters and display mux stay in the top-level block.

## Test plan
- Reset mid-PLAY with score 7, time_left 12 -> next cycle state IDLE, score 0, time_left 0, mode 00.
- IDLE, start pressed with mode 00 -> stays IDLE; press [2] then start -> mode 11, COUNTDOWN, display 3.
- COUNTDOWN_SEC=3: three tick_1hz_i -> PLAY on third, time_left = GAME_SEC, score 0; mole_step_o mirrors tick_5hz_i only.
- PLAY, 5 whacks including one on the final tick -> DONE, score 5, game_over_o 1, display 5.
- Score at 16'hFFFF plus whack -> stays 16'hFFFF.
- With WHACK_HIGH_SCORE_EN: games scoring 4 then 2 -> high_score_o 4 after both; without macro -> 0 throughout.
